// File: rtl/ahb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arb_pkg
// Description : Shared AHB transfer/burst encodings and burst length helper
//               for the AHB bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    // Undefined-length bursts report 1 so they never block rearbitration.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4  : beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8  : beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16 : beats = 5'd16;
            default                      : beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage : ahb_arb_pkg
`default_nettype wire

// File: rtl/ahb_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arb_rr_pick
// Description : Combinational rotating-priority picker; search starts one
//               above the last owner and the last owner is considered last.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_arb_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int MASTER_W    = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MASTER_W-1:0]    last,
    input  logic [MASTER_W-1:0]    dflt,
    output logic [MASTER_W-1:0]    winner,
    output logic                   any_req
);

    logic [MASTER_W-1:0] w_idx;
    logic [MASTER_W-1:0] w_winner;

    // Walk the rotation backwards so the nearest requester overwrites the rest.
    always_comb begin
        w_winner = dflt;
        w_idx    = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            w_idx = MASTER_W'((int'(last) + i) % NUM_MASTERS);
            if (req[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    assign winner  = w_winner;
    assign any_req = |req;

endmodule : ahb_arb_rr_pick
`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bus_arbiter
// Description : Round-robin AHB arbiter with lock support and default-master
//               parking. Define AHB_ARB_BURST_HOLD_EN to keep fixed-length
//               bursts from being split.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int MASTER_W       = $clog2(NUM_MASTERS),
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MASTER_W-1:0]    hmaster,
    output logic [MASTER_W-1:0]    hmaster_d,
    output logic                   hmastlock
);

    localparam logic [NUM_MASTERS-1:0] c_one      = NUM_MASTERS'(1);
    localparam logic [MASTER_W-1:0]    c_dflt_idx = MASTER_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] c_dflt_oh  = c_one << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] r_hgrant;
    logic [MASTER_W-1:0]    r_hmaster;
    logic [MASTER_W-1:0]    r_hmaster_d;
    logic                   r_hmastlock;

    logic [MASTER_W-1:0]    w_winner;
    logic                   w_any_req;
    logic [MASTER_W-1:0]    w_grant_idx;
    logic                   w_lock_hold;
    logic                   w_mid_burst;
    logic                   w_burst_hold;
    logic                   w_arb_ok;

    ahb_arb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .MASTER_W    (MASTER_W)
    ) u_pick (
        .req     (hbusreq),
        .last    (r_hmaster),
        .dflt    (c_dflt_idx),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_hgrant[i]) begin
                w_grant_idx = MASTER_W'(i);
            end
        end
    end

`ifdef AHB_ARB_BURST_HOLD_EN
    logic [4:0] r_beats_left;
    logic [4:0] w_len;

    assign w_len        = burst_beats(hburst);
    assign w_burst_hold = ((htrans == HTRANS_NONSEQ) && (w_len > 5'd1)) ||
                          ((htrans == HTRANS_SEQ)    && (r_beats_left > 5'd1));

    // Beats remaining after the current accepted address phase; BUSY/IDLE hold.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_beats_left <= '0;
        end else if (hready) begin
            if (htrans == HTRANS_NONSEQ) begin
                r_beats_left <= w_len - 5'd1;
            end else if ((htrans == HTRANS_SEQ) && (r_beats_left != 5'd0)) begin
                r_beats_left <= r_beats_left - 5'd1;
            end
        end
    end

    logic w_unused_ok;
    assign w_unused_ok = w_any_req;
`else
    assign w_burst_hold = 1'b0;

    logic w_unused_ok;
    assign w_unused_ok = w_any_req ^ (^hburst);
`endif

    assign w_lock_hold = r_hmastlock & hlock[r_hmaster];
    assign w_mid_burst = (htrans == HTRANS_BUSY);
    assign w_arb_ok    = hready & ~w_lock_hold & ~w_mid_burst & ~w_burst_hold;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_hgrant    <= c_dflt_oh;
            r_hmaster   <= c_dflt_idx;
            r_hmaster_d <= c_dflt_idx;
            r_hmastlock <= 1'b0;
        end else begin
            if (w_arb_ok) begin
                r_hgrant <= c_one << w_winner;
            end
            // Ownership follows the grant only on accepted address phases.
            if (hready) begin
                r_hmaster   <= w_grant_idx;
                r_hmastlock <= hlock[w_grant_idx];
                r_hmaster_d <= r_hmaster;
            end
        end
    end

    assign hgrant    = r_hgrant;
    assign hmaster   = r_hmaster;
    assign hmaster_d = r_hmaster_d;
    assign hmastlock = r_hmastlock;

endmodule : ahb_bus_arbiter
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_bus_arbiter
// Description : Scoreboard bench for ahb_bus_arbiter with a transaction-level
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_bus_arbiter;

    localparam int N    = 4;
    localparam int W    = 2;
    localparam int DEFM = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] hbusreq;
    logic [N-1:0] hlock;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic         hready;
    logic [N-1:0] hgrant;
    logic [W-1:0] hmaster;
    logic [W-1:0] hmaster_d;
    logic         hmastlock;

    ahb_bus_arbiter #(
        .NUM_MASTERS    (N),
        .MASTER_W       (W),
        .DEFAULT_MASTER (DEFM)
    ) dut (
        .hclk      (clk),
        .hreset    (rst),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmaster_d (hmaster_d),
        .hmastlock (hmastlock)
    );

    always #5 clk = ~clk;

    typedef struct {
        int grant;
        int owner;
        int owner_d;
        bit locked;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: who holds the grant, who owns address/data phase.
    int m_grant, m_owner, m_owner_d, m_beats;
    bit m_lock;

    function automatic int beats_of(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    function automatic int next_in_rotation(input logic [N-1:0] req, input int owner);
        for (int k = 1; k <= N; k++) begin
            if (req[(owner + k) % N]) return (owner + k) % N;
        end
        return DEFM;
    endfunction

    task automatic model_step(input bit r, input logic [N-1:0] req,
                              input logic [N-1:0] lk, input logic [1:0] tr,
                              input logic [2:0] bu, input bit rdy);
        int  ng, no, nd, nb;
        bit  nl, keep;
        exp_t e;
        ng = m_grant; no = m_owner; nd = m_owner_d; nl = m_lock; nb = m_beats;
        if (r) begin
            ng = DEFM; no = DEFM; nd = DEFM; nl = 1'b0; nb = 0;
        end else begin
            keep = (m_lock && lk[m_owner]) || (tr == 2'd1);
`ifdef AHB_ARB_BURST_HOLD_EN
            if ((tr == 2'd2 && beats_of(bu) > 1) || (tr == 2'd3 && m_beats > 1)) keep = 1'b1;
            if (rdy && tr == 2'd2) nb = beats_of(bu) - 1;
            else if (rdy && tr == 2'd3 && m_beats > 0) nb = m_beats - 1;
`endif
            if (rdy && !keep) ng = next_in_rotation(req, m_owner);
            if (rdy) begin
                no = m_grant;
                nl = lk[m_grant];
                nd = m_owner;
            end
        end
        m_grant = ng; m_owner = no; m_owner_d = nd; m_lock = nl; m_beats = nb;
        e.grant = ng; e.owner = no; e.owner_d = nd; e.locked = nl;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input logic [N-1:0] req, input logic [N-1:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu, input bit rdy);
        @(negedge clk);
        rst = r; hbusreq = req; hlock = lk; htrans = tr; hburst = bu; hready = rdy;
        model_step(r, req, lk, tr, bu, rdy);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: every post-edge sample is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hgrant",    int'(hgrant),    1 << e.grant);
                chk("hmaster",   int'(hmaster),   e.owner);
                chk("hmaster_d", int'(hmaster_d), e.owner_d);
                chk("hmastlock", int'(hmastlock), int'(e.locked));
            end
        end
    end

    initial begin
        int wait_cnt;
        logic [N-1:0] rq, lk;
        logic [1:0]   tr;
        rst = 1'b1; hbusreq = '0; hlock = '0; htrans = 2'd0; hburst = 3'd0; hready = 1'b1;
        m_grant = DEFM; m_owner = DEFM; m_owner_d = DEFM; m_lock = 1'b0; m_beats = 0;

        // Reset, then park on the default master.
        repeat (2)  cyc(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1);
        repeat (10) cyc(0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1);
        // Rotation among masters 1..3 with single transfers.
        repeat (14) cyc(0, 4'b1110, 4'b0000, 2'd2, 3'd0, 1);
        // Master 2 locked sequence while others request, then release.
        repeat (4)  cyc(0, 4'b0100, 4'b0100, 2'd2, 3'd0, 1);
        repeat (3)  cyc(0, 4'b1011, 4'b0100, 2'd2, 3'd0, 1);
        repeat (4)  cyc(0, 4'b1011, 4'b0000, 2'd2, 3'd0, 1);
        // Wait states while the grant moves to master 1.
        cyc(0, 4'b0010, 4'b0000, 2'd0, 3'd0, 1);
        repeat (4)  cyc(0, 4'b0010, 4'b0000, 2'd2, 3'd0, 0);
        repeat (3)  cyc(0, 4'b0010, 4'b0000, 2'd2, 3'd0, 1);
        // BUSY inside an INCR burst by master 1 with master 3 requesting.
        cyc(0, 4'b1010, 4'b0000, 2'd2, 3'd1, 1);
        repeat (3)  cyc(0, 4'b1010, 4'b0000, 2'd1, 3'd1, 1);
        repeat (2)  cyc(0, 4'b1010, 4'b0000, 2'd3, 3'd1, 1);
        // Master 1 runs INCR8 while master 2 requests.
        repeat (3)  cyc(0, 4'b0010, 4'b0000, 2'd0, 3'd0, 1);
        cyc(0, 4'b0110, 4'b0000, 2'd2, 3'd5, 1);
        repeat (7)  cyc(0, 4'b0110, 4'b0000, 2'd3, 3'd5, 1);
        repeat (3)  cyc(0, 4'b0110, 4'b0000, 2'd0, 3'd0, 1);

        // Random traffic, with an occasional reset mid-flight.
        for (int c = 0; c < 3000; c++) begin
            rq = N'($urandom);
            lk = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            tr = 2'($urandom);
            cyc(($urandom_range(0, 199) == 0), rq, lk, tr, 3'($urandom),
                ($urandom_range(0, 3) != 0));
        end
        cyc(0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ahb_bus_arbiter
`default_nettype wire

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- AHB arbiter paired with the AHB master models on a shared bus.
- Consumes each master's hbusreq/hlock plus the muxed htrans/hburst/hready of the current owner.
- Drives per-master hgrant, hmaster (address-phase owner), hmaster_d (data-phase owner) and hmastlock to the address/data muxes and slaves.
- Round-robin policy; honours locked sequences; parks on a default master when the bus is idle.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
MASTER_W, $clog2(NUM_MASTERS), width of the hmaster index
DEFAULT_MASTER, 0, index granted when nothing requests and after reset

Ports:
hclk  input  1  bus clock; all state updates on rising edge
hreset  input  1  synchronous reset, active-high
hbusreq  input  NUM_MASTERS  per-master bus request
hlock  input  NUM_MASTERS  per-master lock request
htrans  input  2  muxed transfer type of current owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
hburst  input  3  muxed burst type of current owner
hready  input  1  bus ready from slave mux
hgrant  output  NUM_MASTERS  one-hot grant
hmaster  output  MASTER_W  address-phase owner index
hmaster_d  output  MASTER_W  data-phase owner index
hmastlock  output  1  current address phase is locked

Behaviour:
- Reset (hreset=1 at edge): hgrant=one-hot(DEFAULT_MASTER), hmaster=hmaster_d=DEFAULT_MASTER, hmastlock=0, beats_left=0. Reset mid-burst abandons the burst; there is no drain.
- lock_hold = hmastlock & hlock[hmaster].
- mid_burst = (htrans==BUSY).
- arb_ok = hready & ~lock_hold & ~mid_burst & ~burst_hold. burst_hold=0 unless the optional feature is compiled in.
- Pick (combinational): search rotates from hmaster+1 mod NUM_MASTERS upward, wrapping. The first set hbusreq bit wins. If no request is set, the winner is DEFAULT_MASTER. The current owner is searched last, so it keeps the bus only if it is the sole requester.
- Edge with arb_ok=1: hgrant <= one-hot(winner). With arb_ok=0, hgrant holds.
- Edge with hready=1:
  - hmaster <= index(hgrant).
  - hmastlock <= hlock[index(hgrant)].
  - hmaster_d <= hmaster.
- With hready=0, all three hold.
- Grant-to-ownership latency: one hready-qualified cycle. hmaster_d lags hmaster by one accepted address phase.
- Handover gap: an owner losing grant at edge E still owns the address phase of cycle E+1 and must drive IDLE there. This one-cycle gap is accepted.
- Lock:
  - While lock_hold, no rearbitration, even if higher-rotation requests arrive.
  - When the owner drops hlock, hmastlock clears at the next hready edge.
  - Arbitration resumes the cycle after that edge.
- Simultaneous requests with the owner releasing: the rotation decides. Example: owner 1, requests {0,2,3} → 2 wins.
- hbusreq deasserted after grant: grant holds until the next arb_ok. A parked master may issue IDLE indefinitely.

Optional Feature:
- Macro: AHB_ARB_BURST_HOLD_EN.
- With the macro:
  - Fixed-length bursts (WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16 beats) are never split.
  - A 5-bit beats_left counter loads len-1 on an accepted NONSEQ of a fixed burst.
  - It decrements on each accepted SEQ and holds on BUSY.
  - burst_hold = (htrans==NONSEQ & fixed & len>1) | (htrans==SEQ & beats_left>1).
  - Rearbitration therefore happens only at the last beat's address phase.
- Without the macro: burst_hold=0 and beats_left is absent. Rearbitration is allowed on any non-BUSY hready cycle, and masters handle early burst termination.

Decomposition:
- Package ahb_arb_pkg: HTRANS_* and HBURST_* localparams, and function burst_beats(hburst) returning 1/4/8/16 (INCR/SINGLE→1).
- Sub-module ahb_arb_rr_pick: combinational rotating-priority picker.
  - Inputs: req, last index, default index.
  - Outputs: winner index and any_req.
- Everything else lives in the top.

Test Plan (NUM_MASTERS=4, DEFAULT_MASTER=0):
- Reset then no requests → hgrant=4'b0001, hmaster=0, hmastlock=0 across 10 cycles.
- hbusreq=4'b1110 held, htrans=NONSEQ singles, hready=1 → hgrant cycles 2→3→1→2…, with hmaster following one cycle later.
- Master 2 granted, hlock[2]=1 for 3 NONSEQs, hbusreq=4'b1011 → hgrant stays 4'b0100 and hmastlock=1 until hlock drops; next grant goes to master 3.
- hready=0 for 4 cycles while hgrant changes to master 1 → hmaster and hmaster_d frozen; hmaster=1 on the first hready=1 edge.
- BUSY inserted mid-INCR burst by master 1 with master 3 requesting → no grant change during BUSY cycles.
- With AHB_ARB_BURST_HOLD_EN: master 1 runs an INCR8 while master 2 requests → hgrant changes only at the edge ending the 8th address phase. Without the macro, hgrant changes at the first hready edge.
